// File: rtl/ascensor_pkg.sv
// ascensor_pkg
// Shared definitions for the elevator cabin sequencer:
//   - motor drive encodings (off / up / down)
//   - sequencer state enumeration
//   - default number of floors
package ascensor_pkg;

  localparam int N_PISOS_DEF = 10;

  localparam logic [1:0] MOTOR_PARO = 2'b00;
  localparam logic [1:0] MOTOR_SUBE = 2'b01;
  localparam logic [1:0] MOTOR_BAJA = 2'b10;

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    MOVIENDO = 3'd1,
    ABIERTA  = 3'd2,
    CERRANDO = 3'd3,
    FALLA    = 3'd4
  } estado_t;

endpackage

// File: rtl/temporizador_carga.sv
// temporizador_carga
// Loadable down-counter shared by the door-hold timer and the travel
// watchdog (only one of them runs in any given state).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (count cleared)
//   carga       : load valor this edge (has priority over en)
//   en          : decrement this edge (saturates at zero)
//   valor       : load value
//   cero        : terminal-count flag, high in the cycle whose edge brings
//                 the count to zero, so the owner can change state on the
//                 same edge the count expires
module temporizador_carga #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         carga,
  input  logic         en,
  input  logic [W-1:0] valor,
  output logic         cero
);

  logic [W-1:0] cuenta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cuenta <= '0;
    end else if (carga) begin
      cuenta <= valor;
    end else if (en && (cuenta != '0)) begin
      cuenta <= cuenta - 1'b1;
    end
  end

  // A count already sitting at zero also reports expiry so a zero-length
  // timer cannot stall its owner.
  assign cero = en && !carga && (cuenta <= W'(1));

endmodule

// File: rtl/secuenciador_parada.sv
// secuenciador_parada
// Cabin actuator sequencer: drives the motor from the scheduler's command,
// tracks the current floor from the floor-alignment sensor, stops at
// requested floors and runs the door open/hold/close cycle.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   motor_cmd       : scheduler command 00 stop, 01 up, 10 down, 11 = stop
//   solicitudes     : pending requests, bit i = floor i
//   sensor_piso     : one-cycle pulse when cabin aligns with next floor
//   obstaculo       : door obstruction (level)
//   puerta_cerrada  : door fully closed (level)
//   motor           : motor drive 00 off, 01 up, 10 down
//   puerta_abrir    : door open drive
//   piso_actual     : current floor index
//   cambio_piso     : one-cycle pulse together with a new piso_actual value
//   esperar         : high while the door cycle is in progress
//   atendido        : one-hot one-cycle pulse clearing the served request
//   falla           : watchdog fault, sticky until reset
//   estado_dbg      : current sequencer state
// Handshake: there is no valid/ready pair; the scheduler sees stops via
// cambio_piso/atendido pulses and holds off while esperar is high.
// Every output is a register loaded from the next-state decision, so an
// output reflects the state it belongs to from that state's first cycle.
module secuenciador_parada
  import ascensor_pkg::*;
#(
  parameter int N_PISOS  = N_PISOS_DEF,
  parameter int T_PUERTA = 50,
  parameter int T_VIAJE  = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         motor_cmd,
  input  logic [N_PISOS-1:0] solicitudes,
  input  logic               sensor_piso,
  input  logic               obstaculo,
  input  logic               puerta_cerrada,
  output logic [1:0]         motor,
  output logic               puerta_abrir,
  output logic [3:0]         piso_actual,
  output logic               cambio_piso,
  output logic               esperar,
  output logic [N_PISOS-1:0] atendido,
  output logic               falla,
  output estado_t            estado_dbg
);

  localparam int T_MAX = (T_PUERTA > T_VIAJE) ? T_PUERTA : T_VIAJE;
  localparam int CW    = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] CARGA_PUERTA = CW'(T_PUERTA);
  localparam logic [CW-1:0] CARGA_VIAJE  = CW'(T_VIAJE);
  localparam logic [3:0]    PISO_MAX     = 4'(N_PISOS - 1);

  estado_t             estado, estado_sig;
  logic [1:0]          dir, dir_sig;
  logic [3:0]          piso_sig, piso_nuevo;
  logic                cambio_sig;
  logic [N_PISOS-1:0]  atendido_sig;
  logic                t_carga, t_en, t_cero;
  logic [CW-1:0]       t_valor;

  temporizador_carga #(.W(CW)) u_temporizador (
    .clk   (clk),
    .rst_n (rst_n),
    .carga (t_carga),
    .en    (t_en),
    .valor (t_valor),
    .cero  (t_cero)
  );

  // Floor reached on the next sensor pulse; saturates at the shaft ends.
  always_comb begin
    piso_nuevo = piso_actual;
    if (dir == MOTOR_SUBE) begin
      if (piso_actual < PISO_MAX) piso_nuevo = piso_actual + 4'd1;
    end else if (dir == MOTOR_BAJA) begin
      if (piso_actual > 4'd0) piso_nuevo = piso_actual - 4'd1;
    end
  end

  always_comb begin
    estado_sig   = estado;
    dir_sig      = dir;
    piso_sig     = piso_actual;
    cambio_sig   = 1'b0;
    atendido_sig = '0;
    t_carga      = 1'b0;
    t_en         = 1'b0;
    t_valor      = CARGA_PUERTA;

    case (estado)
      REPOSO: begin
        if (solicitudes[piso_actual]) begin
          estado_sig                = ABIERTA;
          t_carga                   = 1'b1;
          atendido_sig[piso_actual] = 1'b1;
        end else if ((motor_cmd == MOTOR_SUBE) && (piso_actual < PISO_MAX)) begin
          estado_sig = MOVIENDO;
          dir_sig    = MOTOR_SUBE;
          t_carga    = 1'b1;
          t_valor    = CARGA_VIAJE;
        end else if ((motor_cmd == MOTOR_BAJA) && (piso_actual > 4'd0)) begin
          estado_sig = MOVIENDO;
          dir_sig    = MOTOR_BAJA;
          t_carga    = 1'b1;
          t_valor    = CARGA_VIAJE;
        end
      end

      MOVIENDO: begin
        if (sensor_piso) begin
          piso_sig   = piso_nuevo;
          cambio_sig = 1'b1;
          // Stop decisions look at the floor just reached, not the old one.
          if (solicitudes[piso_nuevo]) begin
            estado_sig               = ABIERTA;
            t_carga                  = 1'b1;
            atendido_sig[piso_nuevo] = 1'b1;
          end else if ((piso_nuevo == 4'd0) || (piso_nuevo == PISO_MAX)) begin
            estado_sig = REPOSO;
          end else begin
            t_carga = 1'b1;
            t_valor = CARGA_VIAJE;
          end
        end else begin
          t_en = 1'b1;
          if (t_cero) estado_sig = FALLA;
        end
      end

      ABIERTA: begin
        if (obstaculo) begin
          t_carga = 1'b1;
        end else begin
          t_en = 1'b1;
          if (t_cero) estado_sig = CERRANDO;
        end
      end

      CERRANDO: begin
        // Reopening after an obstruction does not re-serve the floor.
        if (obstaculo) begin
          estado_sig = ABIERTA;
          t_carga    = 1'b1;
        end else if (puerta_cerrada) begin
          estado_sig = REPOSO;
        end
      end

      FALLA: begin
        estado_sig = FALLA;
      end

      default: begin
        estado_sig = REPOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado       <= REPOSO;
      dir          <= MOTOR_PARO;
      piso_actual  <= 4'd0;
      motor        <= MOTOR_PARO;
      puerta_abrir <= 1'b0;
      cambio_piso  <= 1'b0;
      esperar      <= 1'b0;
      atendido     <= '0;
      falla        <= 1'b0;
    end else begin
      estado       <= estado_sig;
      dir          <= dir_sig;
      piso_actual  <= piso_sig;
      motor        <= (estado_sig == MOVIENDO) ? dir_sig : MOTOR_PARO;
      puerta_abrir <= (estado_sig == ABIERTA);
      cambio_piso  <= cambio_sig;
      esperar      <= (estado_sig == ABIERTA) || (estado_sig == CERRANDO);
      atendido     <= atendido_sig;
      falla        <= (estado_sig == FALLA);
    end
  end

  assign estado_dbg = estado;

endmodule
